// File: rtl/spi_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bus_arb
//  Description : Arbitrates the inertial and A2D interfaces onto one shared
//                SPI master; optional macro INRT_PRIO_EN selects fixed
//                inertial priority instead of round-robin.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_bus_arb #(
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_inrt,
    input  logic [15:0] cmd_inrt,
    input  logic        req_a2d,
    input  logic [15:0] cmd_a2d,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        sel_a2d,
    output logic        done_inrt,
    output logic        done_a2d,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        tmo_err
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int GW = $clog2(GAP_CYC) + 1;
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] c_gap_last = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_tmo_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          w_any_req;
    logic          w_gnt_a2d;

    assign w_any_req = req_inrt | req_a2d;

`ifdef INRT_PRIO_EN
    assign w_gnt_a2d = req_a2d & ~req_inrt;
`else
    logic r_last_gnt;   // 1 = A2D was granted last
    assign w_gnt_a2d = req_a2d & (~req_inrt | ~r_last_gnt);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tmo_cnt <= '0;
            r_gap_cnt <= '0;
            wrt       <= 1'b0;
            cmd       <= 16'h0000;
            sel_a2d   <= 1'b0;
            done_inrt <= 1'b0;
            done_a2d  <= 1'b0;
            rd_data   <= 16'h0000;
            busy      <= 1'b0;
            tmo_err   <= 1'b0;
`ifndef INRT_PRIO_EN
            r_last_gnt <= 1'b1;
`endif
        end else begin
            wrt       <= 1'b0;
            done_inrt <= 1'b0;
            done_a2d  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        cmd     <= w_gnt_a2d ? cmd_a2d : cmd_inrt;
                        sel_a2d <= w_gnt_a2d;
`ifndef INRT_PRIO_EN
                        r_last_gnt <= w_gnt_a2d;
`endif
                        wrt     <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_tmo_cnt <= '0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    // A completion on the expiry clock takes precedence over the abort
                    if (spi_done) begin
                        rd_data   <= spi_rd;
                        done_a2d  <= sel_a2d;
                        done_inrt <= ~sel_a2d;
                        r_gap_cnt <= '0;
                        r_state   <= GAP;
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        rd_data   <= 16'hFFFF;
                        tmo_err   <= 1'b1;
                        done_a2d  <= sel_a2d;
                        done_inrt <= ~sel_a2d;
                        r_gap_cnt <= '0;
                        r_state   <= GAP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_bus_arb
//  Description : Directed self-checking bench for spi_bus_arb.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_bus_arb;

    localparam int GAP = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_inrt, req_a2d, spi_done;
    logic [15:0] cmd_inrt, cmd_a2d, spi_rd;
    logic        wrt, sel_a2d, done_inrt, done_a2d, busy, tmo_err;
    logic [15:0] cmd, rd_data;

    spi_bus_arb #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_inrt(req_inrt), .cmd_inrt(cmd_inrt),
        .req_a2d(req_a2d), .cmd_a2d(cmd_a2d),
        .spi_done(spi_done), .spi_rd(spi_rd),
        .wrt(wrt), .cmd(cmd), .sel_a2d(sel_a2d),
        .done_inrt(done_inrt), .done_a2d(done_a2d),
        .rd_data(rd_data), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_di = 0, n_da = 0, n_both = 0;
    int total = 0, bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_inrt) n_di = n_di + 1;
        if (done_a2d)  n_da = n_da + 1;
        if (done_inrt && done_a2d) n_both = n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wrt(input string tag);
        int n = 0;
        while (wrt !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_wrt_seen"}, 32'(wrt), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_inrt !== 1'b1 && done_a2d !== 1'b1 && n < TMO + 50) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_inrt | done_a2d), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_done(input logic [15:0] d);
        spi_done = 1'b1;
        spi_rd   = d;
        tick();
        spi_done = 1'b0;
        spi_rd   = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  wc, dc, nd;
        logic exp_a2d;

        rst = 1'b1; req_inrt = 1'b0; req_a2d = 1'b0; spi_done = 1'b0;
        cmd_inrt = 16'h0; cmd_a2d = 16'h0; spi_rd = 16'h0;
        tick(); tick();
        chk("rst_ctl", 32'({wrt, done_inrt, done_a2d, busy, sel_a2d, tmo_err}), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        rst = 1'b0;
        tick();

        // single inertial transaction, completion 5 clocks after wrt
        cmd_inrt = 16'hA2C5; req_inrt = 1'b1;
        tick();
        chk("t1_wrt", 32'(wrt), 32'd1);
        chk("t1_sel", 32'(sel_a2d), 32'd0);
        chk("t1_cmd", 32'(cmd), 32'hA2C5);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_wrt_pulse", 32'(wrt), 32'd0);
        repeat (4) tick();
        pulse_done(16'h1234);
        chk("t1_done", 32'({done_inrt, done_a2d}), 32'b10);
        chk("t1_rd", 32'(rd_data), 32'h1234);
        req_inrt = 1'b0;
        tick();
        chk("t1_done_once", 32'(done_inrt), 32'd0);
        chk("t1_rd_hold", 32'(rd_data), 32'h1234);
        wait_idle("t1");

        // contention with both requests held across four grants
        do_reset();
        cmd_inrt = 16'hA100; cmd_a2d = 16'h0C00;
        req_inrt = 1'b1; req_a2d = 1'b1;
        dc = 0;
        for (int i = 0; i < 4; i++) begin
            wait_wrt("t2");
`ifdef INRT_PRIO_EN
            exp_a2d = 1'b0;
`else
            exp_a2d = ((i % 2) == 1);
`endif
            chk("t2_sel", 32'(sel_a2d), 32'(exp_a2d));
            chk("t2_cmd", 32'(cmd), exp_a2d ? 32'h0C00 : 32'hA100);
            if (i > 0) chk("t2_gap", 32'(cyc - dc), 32'(GAP + 1));
            repeat (2) tick();
            pulse_done(16'h5000 + 16'(i));
            dc = cyc;
            chk("t2_done", 32'({done_inrt, done_a2d}), exp_a2d ? 32'b01 : 32'b10);
            chk("t2_rd", 32'(rd_data), 32'h5000 + 32'(i));
        end
        req_inrt = 1'b0; req_a2d = 1'b0;
        wait_idle("t2");

        // completion on the expiry clock wins over the abort
        cmd_a2d = 16'hB00B; req_a2d = 1'b1;
        wait_wrt("t4a");
        repeat (TMO) tick();
        pulse_done(16'h7777);
        chk("t4a_done", 32'({done_inrt, done_a2d}), 32'b01);
        chk("t4a_rd", 32'(rd_data), 32'h7777);
        chk("t4a_tmo", 32'(tmo_err), 32'd0);
        req_a2d = 1'b0;
        wait_idle("t4a");

        // genuine timeout
        cmd_a2d = 16'hB00C; req_a2d = 1'b1;
        wait_wrt("t4b");
        wc = cyc;
        wait_done("t4b");
        chk("t4b_lat", 32'(cyc - wc), 32'(TMO + 1));
        chk("t4b_done", 32'({done_inrt, done_a2d}), 32'b01);
        chk("t4b_rd", 32'(rd_data), 32'hFFFF);
        chk("t4b_tmo", 32'(tmo_err), 32'd1);
        req_a2d = 1'b0;
        wait_idle("t4b");
        chk("t4b_tmo_sticky", 32'(tmo_err), 32'd1);

        // asynchronous reset in the middle of an inertial WAIT
        cmd_inrt = 16'hA555; req_inrt = 1'b1;
        wait_wrt("t5");
        repeat (2) tick();
        nd = n_di + n_da;
        #2 rst = 1'b1;
        #1;
        chk("t5_async", 32'({wrt, done_inrt, done_a2d, busy, sel_a2d, tmo_err}), 32'd0);
        tick();
        rst = 1'b0;
        req_inrt = 1'b1; req_a2d = 1'b1;
        wait_wrt("t5");
        chk("t5_nodone", 32'(n_di + n_da), 32'(nd));
        chk("t5_inrt_first", 32'(sel_a2d), 32'd0);
        repeat (2) tick();
        pulse_done(16'h3333);
        chk("t5_done", 32'({done_inrt, done_a2d}), 32'b10);
        req_inrt = 1'b0;
        wait_wrt("t5b");
        chk("t5b_sel", 32'(sel_a2d), 32'd1);
        tick();
        pulse_done(16'h4444);
        chk("t5b_rd", 32'(rd_data), 32'h4444);
        req_a2d = 1'b0;

        // spurious spi_done during GAP and in IDLE
        tick();
        pulse_done(16'hBAD0);
        chk("t6_gap_nodone", 32'({done_inrt, done_a2d}), 32'd0);
        chk("t6_gap_rd", 32'(rd_data), 32'h4444);
        wait_idle("t6");
        pulse_done(16'hDEAD);
        chk("t6_idle_nodone", 32'({done_inrt, done_a2d}), 32'd0);
        chk("t6_idle_rd", 32'(rd_data), 32'h4444);
        chk("t6_idle_wrt", 32'(wrt), 32'd0);
        tick();
        chk("t6_idle_busy", 32'(busy), 32'd0);

        chk("both_done", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
